traffic_intersection_ctrl: RTL

Parametrised two-road intersection controller with pedestrian crossing and maintenance flash mode. Drives north-south and east-west RGB signal heads plus a walk lamp. A single-clock prescaler tick sequences a seven-state FSM; there are no derived clocks. It sits directly between the board clock and the RGB LED pins.

---
 rtl/traffic_pkg.sv | 45 ++++
 rtl/tick_gen.sv | 33 +++
 rtl/traffic_intersection_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared state, direction and lamp encodings for the intersection controller.
package traffic_pkg;

    localparam int unsigned RGB_W = 3;

    typedef logic [RGB_W-1:0] rgb_t;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        EW_GREEN  = 3'd2,
        EW_YELLOW = 3'd3,
        ALL_RED   = 3'd4,
        WALK      = 3'd5,
        FLASH     = 3'd6
    } state_t;

    typedef enum logic {
        NS = 1'b0,
        EW = 1'b1
    } dir_t;

    localparam rgb_t RED    = 3'b100;
    localparam rgb_t GREEN  = 3'b010;
    localparam rgb_t YELLOW = 3'b110;
    localparam rgb_t OFF    = 3'b000;

    // Everything driven onto the LED pins in one bundle.
    typedef struct packed {
        rgb_t ns;
        rgb_t ew;
        logic walk;
    } lamps_t;

    localparam lamps_t ALL_STOP = '{ns: RED, ew: RED, walk: 1'b0};

    function automatic state_t green_of(input dir_t d);
        return (d == EW) ? EW_GREEN : NS_GREEN;
    endfunction

    function automatic bit ticks_ok(input int unsigned ticks, input int unsigned width);
        return (ticks >= 1) && (64'(ticks) < (64'd1 << width));
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler emitting a one-clock tick at TICK_HZ.
module tick_gen #(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned TICK_HZ = 100
) (
    input  logic clk_100MHz,
    input  logic rst,
    output logic tick_c
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    if ((CLK_HZ % TICK_HZ) != 0 || DIV < 1) begin : g_bad_div
        $error("tick_gen: CLK_HZ must be a non-zero multiple of TICK_HZ");
    end

    logic [PW-1:0] prescaler;

    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
        end else if (prescaler == LAST) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

    assign tick_c = (prescaler == LAST);

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// Two-road intersection controller with pedestrian walk phase and maintenance flash.
// Lamp outputs are registered from the next-state decode so they move with the state.
module traffic_intersection_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned TICK_HZ      = 100,
    parameter int unsigned TW           = 8,
    parameter int unsigned GREEN_TICKS  = 100,
    parameter int unsigned YELLOW_TICKS = 50,
    parameter int unsigned ALLRED_TICKS = 20,
    parameter int unsigned WALK_TICKS   = 80,
    parameter int unsigned FLASH_TICKS  = 50
) (
    input  logic             clk_100MHz,
    input  logic             rst,
    input  logic             ped_req,
    input  logic             flash_mode,
    output logic [RGB_W-1:0] ns_rgb,
    output logic [RGB_W-1:0] ew_rgb,
    output logic             walk,
    output logic             ped_wait
);

    if (!ticks_ok(GREEN_TICKS, TW)  || !ticks_ok(YELLOW_TICKS, TW) ||
        !ticks_ok(ALLRED_TICKS, TW) || !ticks_ok(WALK_TICKS, TW)   ||
        !ticks_ok(FLASH_TICKS, TW)) begin : g_bad_ticks
        $error("traffic_intersection_ctrl: every *_TICKS must be in [1, 2**TW)");
    end

    logic tick_c;

    tick_gen #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_tick_gen (
        .clk_100MHz (clk_100MHz),
        .rst        (rst),
        .tick_c     (tick_c)
    );

    logic ped_meta, ped_sync, ped_sync_d;
    logic flash_meta, flash_sync;
    logic ped_edge;
    logic ped_pending;

    state_t        state, state_nx;
    dir_t          next_dir, dir_nx;
    logic [TW-1:0] timer, timer_nx, dur_m1;
    logic          blink, blink_nx;
    lamps_t        lamps, lamps_nx;

    // Two-flop synchronisers; ped also keeps one extra stage for edge detection.
    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            ped_meta   <= 1'b0;
            ped_sync   <= 1'b0;
            ped_sync_d <= 1'b0;
            flash_meta <= 1'b0;
            flash_sync <= 1'b0;
        end else begin
            ped_meta   <= ped_req;
            ped_sync   <= ped_meta;
            ped_sync_d <= ped_sync;
            flash_meta <= flash_mode;
            flash_sync <= flash_meta;
        end
    end

    assign ped_edge = ped_sync & ~ped_sync_d;

    // Pending request: flash clears it, entering WALK serves it, WALK/FLASH ignore presses.
    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            ped_pending <= 1'b0;
        end else if (tick_c && flash_sync) begin
            ped_pending <= 1'b0;
        end else if (state_nx == WALK && state != WALK) begin
            ped_pending <= 1'b0;
        end else if (ped_edge && state != WALK && state != FLASH) begin
            ped_pending <= 1'b1;
        end
    end

    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            state    <= ALL_RED;
            next_dir <= NS;
            timer    <= '0;
            blink    <= 1'b1;
            lamps    <= ALL_STOP;
        end else begin
            state    <= state_nx;
            next_dir <= dir_nx;
            timer    <= timer_nx;
            blink    <= blink_nx;
            lamps    <= lamps_nx;
        end
    end

    // Next state; flash request outranks every dwell expiry on the same tick.
    always_comb begin
        state_nx = state;
        dir_nx   = next_dir;
        timer_nx = timer;
        blink_nx = blink;
        dur_m1   = TW'(FLASH_TICKS - 1);

        case (state)
            NS_GREEN, EW_GREEN:   dur_m1 = TW'(GREEN_TICKS - 1);
            NS_YELLOW, EW_YELLOW: dur_m1 = TW'(YELLOW_TICKS - 1);
            ALL_RED:              dur_m1 = TW'(ALLRED_TICKS - 1);
            WALK:                 dur_m1 = TW'(WALK_TICKS - 1);
            default:              dur_m1 = TW'(FLASH_TICKS - 1);
        endcase

        if (tick_c) begin
            if (flash_sync) begin
                if (state != FLASH) begin
                    state_nx = FLASH;
                    timer_nx = '0;
                    blink_nx = 1'b1;
                end else if (timer == dur_m1) begin
                    timer_nx = '0;
                    blink_nx = ~blink;
                end else begin
                    timer_nx = timer + TW'(1);
                end
            end else if (state == FLASH) begin
                state_nx = ALL_RED;
                dir_nx   = NS;
                timer_nx = '0;
            end else if (timer == dur_m1) begin
                timer_nx = '0;
                case (state)
                    NS_GREEN:  state_nx = NS_YELLOW;
                    NS_YELLOW: begin
                        state_nx = ALL_RED;
                        dir_nx   = EW;
                    end
                    EW_GREEN:  state_nx = EW_YELLOW;
                    EW_YELLOW: begin
                        state_nx = ALL_RED;
                        dir_nx   = NS;
                    end
                    ALL_RED:   state_nx = (ped_pending || ped_edge) ? WALK : green_of(next_dir);
                    WALK:      state_nx = green_of(next_dir);
                    default:   state_nx = ALL_RED;
                endcase
            end else begin
                timer_nx = timer + TW'(1);
            end
        end
    end

    // Lamp decode from the upcoming state so the pins change on the transition edge.
    always_comb begin
        lamps_nx = ALL_STOP;
        case (state_nx)
            NS_GREEN:  lamps_nx.ns = GREEN;
            NS_YELLOW: lamps_nx.ns = YELLOW;
            EW_GREEN:  lamps_nx.ew = GREEN;
            EW_YELLOW: lamps_nx.ew = YELLOW;
            WALK:      lamps_nx.walk = 1'b1;
            FLASH: begin
                lamps_nx.ns = blink_nx ? YELLOW : OFF;
                lamps_nx.ew = blink_nx ? YELLOW : OFF;
            end
            default:   lamps_nx = ALL_STOP;
        endcase
    end

    assign ns_rgb   = lamps.ns;
    assign ew_rgb   = lamps.ew;
    assign walk     = lamps.walk;
    assign ped_wait = ped_pending;

endmodule
